gpio_irq_ctrl: RTL and testbench

GPIO interrupt source stage: synchronises N external GPIO pins, detects per-pin edge or level events, latches them in a pending register and drives the single aggregated `gpio_plic_irq_o` line into the PLIC's GPIO input (source 2). Software configures and services it over a Wishbone classic slave port on the on-chip peripheral bus, using the same registered single-pulse ack handshake as the other on-chip peripherals.

---
 rtl/gpio_irq_ctrl.sv | 115 +++++++++++
 tb/tb_gpio_irq_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt source: synchronises pins, latches edge/level events into a pending
// register and drives one registered interrupt line, configured over a Wishbone slave.
module gpio_irq_ctrl #(
  parameter int N_PINS = 8,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PINS-1:0] gpio_pin_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic [AW-1:0]     wbs_addr_i,
  input  logic [DW-1:0]     wbs_wdata_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic              wbs_we_i,
  output logic [DW-1:0]     wbs_rdata_o,
  output logic              wbs_ack_o,
  output logic              gpio_plic_irq_o
);

  logic [N_PINS-1:0] s1_q, s2_q, s3_q;
  logic [N_PINS-1:0] irqEn_q, irqEn_d;
  logic [N_PINS-1:0] irqType_q, irqType_d;
  logic [N_PINS-1:0] irqPol_q, irqPol_d;
  logic [N_PINS-1:0] pend_q, pend_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              irq_q, irq_d;

  logic [2:0]        regSel;
  logic              req, wr;
  logic [N_PINS-1:0] wrMask, wdataN, riseEvt, fallEvt, levelEvt, setPend, clrPend;
  logic              unused_bits;

  assign unused_bits = ^{wbs_addr_i[AW-1:5], wbs_addr_i[1:0], wbs_wdata_i, wbs_sel_i};

  // Each pin bit follows the byte enable of the byte lane it lives in.
  for (genvar g = 0; g < N_PINS; g++) begin : g_mask
    assign wrMask[g] = wbs_sel_i[g/8];
  end

  assign regSel   = wbs_addr_i[4:2];
  assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr       = req & wbs_we_i;
  assign wdataN   = wbs_wdata_i[N_PINS-1:0];
  assign riseEvt  = s2_q & ~s3_q;
  assign fallEvt  = ~s2_q & s3_q;
  assign levelEvt = ~(s2_q ^ irqPol_q);
  assign setPend  = (irqType_q & ((irqPol_q & riseEvt) | (~irqPol_q & fallEvt)))
                  | (~irqType_q & levelEvt);

  always_comb begin
    irqEn_d   = irqEn_q;
    irqType_d = irqType_q;
    irqPol_d  = irqPol_q;
    clrPend   = '0;
    rdata_d   = rdata_q;
    ack_d     = req;
    irq_d     = |(pend_q & irqEn_q);
    if (wr) begin
      case (regSel)
        3'd1: irqEn_d   = (irqEn_q & ~wrMask) | (wdataN & wrMask);
        3'd2: irqType_d = (irqType_q & ~wrMask) | (wdataN & wrMask);
        3'd3: irqPol_d  = (irqPol_q & ~wrMask) | (wdataN & wrMask);
        3'd4: clrPend   = wdataN & wrMask;
        default: ;
      endcase
    end
    // Set beats a same-cycle clear, so a level that persists can never be cleared.
    pend_d = (pend_q & ~clrPend) | setPend;
    if (req) begin
      case (regSel)
        3'd0:    rdata_d = DW'(s2_q);
        3'd1:    rdata_d = DW'(irqEn_q);
        3'd2:    rdata_d = DW'(irqType_q);
        3'd3:    rdata_d = DW'(irqPol_q);
        3'd4:    rdata_d = DW'(pend_q);
        3'd5:    rdata_d = DW'(pend_q & irqEn_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      irqEn_q   <= '0;
      irqType_q <= '0;
      irqPol_q  <= '0;
      pend_q    <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      s1_q      <= gpio_pin_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      irqEn_q   <= irqEn_d;
      irqType_q <= irqType_d;
      irqPol_q  <= irqPol_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_rdata_o     = rdata_q;
  assign wbs_ack_o       = wbs_cyc_i & ack_q;
  assign gpio_plic_irq_o = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: per-feature tasks with inline expected values.
module tb_gpio_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gpio_pin_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_addr_i, wbs_wdata_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_rdata_o;
  logic        wbs_ack_o;
  logic        gpio_plic_irq_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd;

  gpio_irq_ctrl #(.N_PINS(8), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .gpio_pin_i(gpio_pin_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_addr_i(wbs_addr_i),
    .wbs_wdata_i(wbs_wdata_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
    .wbs_rdata_o(wbs_rdata_o), .wbs_ack_o(wbs_ack_o), .gpio_plic_irq_o(gpio_plic_irq_o)
  );

  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    gpio_pin_i = 8'h00;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_addr_i = '0; wbs_wdata_i = '0; wbs_sel_i = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the ack edge.
  task automatic busAccess(input logic [2:0] idx, input logic we, input logic [31:0] data,
                           input logic [3:0] sel, output logic [31:0] rdata);
    logic acked;
    wbs_addr_i = {27'b0, idx, 2'b00};
    wbs_we_i = we; wbs_wdata_i = data; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    rdata = wbs_rdata_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (!acked) begin
      failures++;
      $display("[TB] FAIL bus_ack_timeout reg=%0d got=no_ack exp=ack", idx);
    end
  endtask

  task automatic busWrite(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] dummy;
    busAccess(idx, 1'b1, data, sel, dummy);
  endtask

  task automatic busRead(input logic [2:0] idx, output logic [31:0] data);
    busAccess(idx, 1'b0, 32'h0, 4'h0, data);
  endtask

  task automatic test_reset();
    logic [31:0] expVals [6];
    resetDut();
    checks++;
    if ({wbs_ack_o, gpio_plic_irq_o, wbs_rdata_o} !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b/%b/%h exp=0/0/0", wbs_ack_o, gpio_plic_irq_o, wbs_rdata_o);
    end
    // Default level-low mode with all pins low sets every pending bit once reset releases.
    expVals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0};
    for (int r = 0; r < 6; r++) begin
      busRead(3'(r), rd);
      checks++;
      if (rd !== expVals[r]) begin
        failures++;
        $display("[TB] FAIL reset_reg%0d got=%h exp=%h", r, rd, expVals[r]);
      end
    end
  endtask

  task automatic test_rising_edge();
    resetDut();
    busWrite(3'd2, 32'hFF, 4'hF);
    busWrite(3'd3, 32'hFF, 4'hF);
    busWrite(3'd4, 32'hFF, 4'hF);
    busWrite(3'd1, 32'h01, 4'hF);
    gpio_pin_i[0] = 1'b1;
    waitCycles(3);
    checks++;
    if (gpio_plic_irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rise_irq_early got=%b exp=0", gpio_plic_irq_o);
    end
    waitCycles(1);
    checks++;
    if (gpio_plic_irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rise_irq_latency got=%b exp=1", gpio_plic_irq_o);
    end
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'h01) begin
      failures++;
      $display("[TB] FAIL rise_pend got=%h exp=%h", rd, 32'h01);
    end
    busWrite(3'd4, 32'h01, 4'hF);
    checks++;
    if (gpio_plic_irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rise_irq_hold got=%b exp=1", gpio_plic_irq_o);
    end
    waitCycles(1);
    checks++;
    if (gpio_plic_irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rise_irq_clear got=%b exp=0", gpio_plic_irq_o);
    end
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rise_pend_clear got=%h exp=%h", rd, 32'h0);
    end
  endtask

  task automatic test_level_low();
    resetDut();
    busWrite(3'd1, 32'h08, 4'hF);
    waitCycles(2);
    checks++;
    if (gpio_plic_irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL level_irq got=%b exp=1", gpio_plic_irq_o);
    end
    busWrite(3'd4, 32'h08, 4'hF);
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'hFF || gpio_plic_irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL level_w1c_persist got=%h/%b exp=%h/1", rd, gpio_plic_irq_o, 32'hFF);
    end
    gpio_pin_i[3] = 1'b1;
    waitCycles(3);
    busWrite(3'd4, 32'h08, 4'hF);
    waitCycles(1);
    checks++;
    if (gpio_plic_irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL level_irq_clear got=%b exp=0", gpio_plic_irq_o);
    end
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'hF7) begin
      failures++;
      $display("[TB] FAIL level_pend_clear got=%h exp=%h", rd, 32'hF7);
    end
  endtask

  task automatic test_masking();
    resetDut();
    busWrite(3'd2, 32'hFF, 4'hF);
    busWrite(3'd3, 32'h00, 4'hF);
    busWrite(3'd4, 32'hFF, 4'hF);
    gpio_pin_i[5] = 1'b1;
    waitCycles(4);
    gpio_pin_i[5] = 1'b0;
    waitCycles(4);
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'h20) begin
      failures++;
      $display("[TB] FAIL mask_pend got=%h exp=%h", rd, 32'h20);
    end
    busRead(3'd5, rd);
    checks++;
    if (rd !== 32'h0 || gpio_plic_irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mask_status got=%h/%b exp=%h/0", rd, gpio_plic_irq_o, 32'h0);
    end
    busWrite(3'd1, 32'h20, 4'hF);
    checks++;
    if (gpio_plic_irq_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mask_irq_at_ack got=%b exp=0", gpio_plic_irq_o);
    end
    waitCycles(1);
    checks++;
    if (gpio_plic_irq_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mask_irq_enable got=%b exp=1", gpio_plic_irq_o);
    end
    busRead(3'd5, rd);
    checks++;
    if (rd !== 32'h20) begin
      failures++;
      $display("[TB] FAIL mask_status_en got=%h exp=%h", rd, 32'h20);
    end
  endtask

  task automatic test_collision();
    resetDut();
    busWrite(3'd2, 32'hFF, 4'hF);
    busWrite(3'd3, 32'hFF, 4'hF);
    busWrite(3'd4, 32'hFF, 4'hF);
    busWrite(3'd1, 32'h02, 4'hF);
    gpio_pin_i[1] = 1'b1;
    waitCycles(4);
    gpio_pin_i[1] = 1'b0;
    waitCycles(4);
    busWrite(3'd4, 32'h02, 4'hF);
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL collide_pre_clear got=%h exp=%h", rd, 32'h0);
    end
    // The new rising event lands on the pending register at the W1C ack edge.
    gpio_pin_i[1] = 1'b1;
    waitCycles(2);
    busWrite(3'd4, 32'h02, 4'hF);
    busRead(3'd4, rd);
    checks++;
    if (rd !== 32'h02) begin
      failures++;
      $display("[TB] FAIL collide_set_wins got=%h exp=%h", rd, 32'h02);
    end
  endtask

  task automatic test_bus_protocol();
    resetDut();
    wbs_addr_i = 32'h4; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (wbs_ack_o !== ((k % 2) == 0)) begin
        failures++;
        $display("[TB] FAIL b2b_ack cycle=%0d got=%b exp=%b", k, wbs_ack_o, (k % 2) == 0);
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    waitCycles(1);
    gpio_pin_i = 8'hA5;
    waitCycles(3);
    busRead(3'd0, rd);
    checks++;
    if (rd !== 32'hA5) begin
      failures++;
      $display("[TB] FAIL in_reg got=%h exp=%h", rd, 32'hA5);
    end
    busRead(3'd7, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL addr7_read got=%h exp=%h", rd, 32'h0);
    end
    busWrite(3'd1, 32'hFFFF_FFFF, 4'b0001);
    busWrite(3'd1, 32'h0, 4'b0000);
    busWrite(3'd1, 32'h0, 4'b0010);
    busRead(3'd1, rd);
    checks++;
    if (rd !== 32'hFF) begin
      failures++;
      $display("[TB] FAIL sel_write got=%h exp=%h", rd, 32'hFF);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] expVals [5];
    resetDut();
    busWrite(3'd1, 32'hFF, 4'hF);
    waitCycles(2);
    wbs_addr_i = 32'h10; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if (wbs_ack_o !== 1'b1 || gpio_plic_irq_o !== 1'b1 || wbs_rdata_o !== 32'hFF) begin
      failures++;
      $display("[TB] FAIL pre_reset_state got=%b/%b/%h exp=1/1/%h", wbs_ack_o, gpio_plic_irq_o, wbs_rdata_o, 32'hFF);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wbs_ack_o !== 1'b0 || gpio_plic_irq_o !== 1'b0 || wbs_rdata_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs got=%b/%b/%h exp=0/0/0", wbs_ack_o, gpio_plic_irq_o, wbs_rdata_o);
    end
    rst = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    expVals = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h0};
    for (int r = 0; r < 5; r++) begin
      busRead(3'(r + 1), rd);
      checks++;
      if (rd !== expVals[r]) begin
        failures++;
        $display("[TB] FAIL post_reset_reg%0d got=%h exp=%h", r + 1, rd, expVals[r]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    gpio_pin_i = 8'h00;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_addr_i = '0; wbs_wdata_i = '0; wbs_sel_i = 4'h0;
    @(negedge clk);
    test_reset();
    test_rising_edge();
    test_level_low();
    test_masking();
    test_collision();
    test_bus_protocol();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
